// File: rtl/arb2_pkg.sv
// arb2_pkg: shared constants for the two-source stream arbiter.
//   SRC_A / SRC_B : source encoding used for grant, prio and y_sel.
//   DATA_W_DEF    : default payload width.
package arb2_pkg;
  localparam logic SRC_A      = 1'b0;
  localparam logic SRC_B      = 1'b1;
  localparam int   DATA_W_DEF = 8;
endpackage

// File: rtl/mux2.sv
// mux2: single-bit 2:1 select.
//   a, b : inputs (a chosen when sel=0)
//   sel  : select
//   y    : output
module mux2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/arb2_stream.sv
// arb2_stream: round-robin merge of two valid/ready streams into one
// registered output stage (1-cycle latency, 1 beat/cycle throughput).
//   clk, rst               : clock, async active-high reset
//   a_valid/a_ready/a_last : source A handshake, a_data payload
//   b_valid/b_ready/b_last : source B handshake, b_data payload
//   y_valid/y_ready/y_last : merged output handshake, y_data payload
//   y_sel                  : source of the held beat (0=A, 1=B)
// Optional feature: define ARB2_LOCK_EN to keep the grant on one source
// for a whole packet (until its last beat is accepted).
module arb2_stream
  import arb2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_last,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_last,
  input  logic [DATA_W-1:0] b_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              y_last,
  output logic [DATA_W-1:0] y_data,
  output logic              y_sel
);

  logic              y_valid_q, y_valid_d;
  logic [DATA_W-1:0] y_data_q, y_data_d;
  logic              y_last_q, y_last_d;
  logic              y_sel_q, y_sel_d;
  logic              prio_q, prio_d;
`ifdef ARB2_LOCK_EN
  logic              lock_q, lock_d;
  logic              owner_q, owner_d;
`endif

  logic              load_ok, grant, accept;
  logic [DATA_W:0]   a_bus, b_bus, mux_y;

  // Data and last travel together through the per-bit muxes.
  assign a_bus = {a_last, a_data};
  assign b_bus = {b_last, b_data};

  for (genvar i = 0; i <= DATA_W; i++) begin : g_mux
    mux2 u_mux (
      .a   (a_bus[i]),
      .b   (b_bus[i]),
      .sel (grant),
      .y   (mux_y[i])
    );
  end

  // Register may load when empty or when its beat leaves this cycle.
  assign load_ok = !y_valid_q || y_ready;

  always_comb begin
    grant = prio_q;
    if (a_valid && !b_valid)      grant = SRC_A;
    else if (b_valid && !a_valid) grant = SRC_B;
`ifdef ARB2_LOCK_EN
    // Mid-packet: the owner keeps the grant even if it goes idle.
    if (lock_q) grant = owner_q;
`endif
  end

  assign a_ready = load_ok && (grant == SRC_A);
  assign b_ready = load_ok && (grant == SRC_B);
  assign accept  = load_ok && ((grant == SRC_B) ? b_valid : a_valid);

  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;
    y_sel_d   = y_sel_q;
    prio_d    = prio_q;
`ifdef ARB2_LOCK_EN
    lock_d    = lock_q;
    owner_d   = owner_q;
`endif
    if (accept) begin
      y_valid_d = 1'b1;
      y_data_d  = mux_y[DATA_W-1:0];
      y_last_d  = mux_y[DATA_W];
      y_sel_d   = grant;
`ifdef ARB2_LOCK_EN
      if (mux_y[DATA_W]) begin
        lock_d = 1'b0;
        prio_d = ~grant;
      end else begin
        lock_d  = 1'b1;
        owner_d = grant;
      end
`else
      prio_d = ~grant;
`endif
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
      y_sel_q   <= SRC_A;
      prio_q    <= SRC_A;
`ifdef ARB2_LOCK_EN
      lock_q    <= 1'b0;
      owner_q   <= SRC_A;
`endif
    end else begin
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
      y_sel_q   <= y_sel_d;
      prio_q    <= prio_d;
`ifdef ARB2_LOCK_EN
      lock_q    <= lock_d;
      owner_q   <= owner_d;
`endif
    end
  end

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_last  = y_last_q;
  assign y_sel   = y_sel_q;

endmodule

// File: tb/tb_arb2_stream.sv
// tb_arb2_stream: scoreboard bench for arb2_stream. A small reference model
// predicts readies and accepted beats; predicted beats are queued and
// compared as they appear on y_*. Departed beats are logged for directed
// sequence checks. Honors ARB2_LOCK_EN the same way as the design.
module tb_arb2_stream;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_ready, a_last;
  logic [DW-1:0] a_data;
  logic          b_valid, b_ready, b_last;
  logic [DW-1:0] b_data;
  logic          y_valid, y_ready, y_last, y_sel;
  logic [DW-1:0] y_data;

  always #5 clk = ~clk;

  arb2_stream #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_last(a_last), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_last(b_last), .b_data(b_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_last(y_last), .y_data(y_data),
    .y_sel(y_sel)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] sb_q[$];   // {sel, last, data} expected on y
  logic [9:0] log_q[$];  // beats that left the output register
  logic m_prio, m_lock, m_owner, m_yv, m_acc, m_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_prio = 1'b0; m_lock = 1'b0; m_owner = 1'b0; m_yv = 1'b0;
    m_acc = 1'b0; m_grant = 1'b0;
  endtask

  task automatic set_in(input logic av, input logic [7:0] ad, input logic al,
                        input logic bv, input logic [7:0] bd, input logic bl,
                        input logic yr);
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl;
    y_ready = yr;
  endtask

  // One clock: check readies and y against the model, advance the model.
  task automatic cycle();
    logic load_ok, g, lst;
    #1;
    load_ok = !m_yv || y_ready;
    if (m_lock)                   g = m_owner;
    else if (a_valid && !b_valid) g = 1'b0;
    else if (b_valid && !a_valid) g = 1'b1;
    else                          g = m_prio;
    chk("a_ready", a_ready, load_ok && !g);
    chk("b_ready", b_ready, load_ok && g);
    chk("y_valid", y_valid, m_yv);
    if (m_yv) begin
      if (sb_q.size() == 0) chk("sb_empty", 1, 0);
      else chk("y_beat", {y_sel, y_last, y_data}, sb_q[0]);
    end
    m_grant = g;
    m_acc   = load_ok && (g ? b_valid : a_valid);
    lst     = g ? b_last : a_last;
    if (m_yv && y_ready && sb_q.size() > 0) log_q.push_back(sb_q.pop_front());
    if (m_acc) begin
      sb_q.push_back(g ? {1'b1, b_last, b_data} : {1'b0, a_last, a_data});
      m_yv = 1'b1;
`ifdef ARB2_LOCK_EN
      if (lst) begin m_lock = 1'b0; m_prio = !g; end
      else begin m_lock = 1'b1; m_owner = g; end
`else
      m_prio = !g;
`endif
    end else if (y_ready) begin
      m_yv = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    set_in(0, 8'h00, 0, 0, 8'h00, 0, 1);
    repeat (3) cycle();
  endtask

  logic [9:0] exp_lock[4];
  int a_idx;

  initial begin
    rst = 1'b1;
    set_in(0, 8'h00, 0, 0, 8'h00, 0, 0);
    model_reset();
    #2;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_y_last", y_last, 0);
    chk("rst_y_sel", y_sel, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention: strict alternation starting from A.
    log_q.delete();
    set_in(1, 8'h11, 1, 1, 8'h22, 1, 1);
    repeat (4) cycle();
    drain();
    chk("cont_n", log_q.size(), 4);
    if (log_q.size() >= 4) begin
      chk("cont0", log_q[0], {2'b01, 8'h11});
      chk("cont1", log_q[1], {2'b11, 8'h22});
      chk("cont2", log_q[2], {2'b01, 8'h11});
      chk("cont3", log_q[3], {2'b11, 8'h22});
    end

    // Idle left prio at A (last grant was B).
    set_in(1, 8'h11, 1, 1, 8'h22, 1, 0);
    #1;
    chk("idle_prio_a", a_ready, 1);
    chk("idle_prio_b", b_ready, 0);

    // Backpressure: 0x11 held for 3 stalled cycles.
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_data", y_data, 8'h11);
      chk("bp_ardy", a_ready, 0);
      chk("bp_brdy", b_ready, 0);
    end
    y_ready = 1'b1;
    cycle();
    chk("bp_next", y_data, 8'h22);
    drain();

    // Single source B, back-to-back.
    log_q.delete();
    for (int i = 1; i <= 4; i++) begin
      set_in(0, 8'h00, 0, 1, 8'(i), 1, 1);
      cycle();
      chk("single_vld", y_valid, 1);
    end
    drain();
    chk("single_n", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk("single_beat", log_q[i], {2'b11, 8'(i + 1)});

    // Packet: A sends 3 beats, B valid throughout.
`ifdef ARB2_LOCK_EN
    exp_lock[0] = {2'b00, 8'hA1}; exp_lock[1] = {2'b00, 8'hA2};
    exp_lock[2] = {2'b01, 8'hA3}; exp_lock[3] = {2'b11, 8'hB1};
`else
    exp_lock[0] = {2'b00, 8'hA1}; exp_lock[1] = {2'b11, 8'hB1};
    exp_lock[2] = {2'b00, 8'hA2}; exp_lock[3] = {2'b11, 8'hB1};
`endif
    log_q.delete();
    a_idx = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(a_idx < 3, 8'(8'hA1 + a_idx), a_idx == 2, 1, 8'hB1, 1, 1);
      cycle();
      if (m_acc && !m_grant) a_idx++;
    end
    drain();
    chk("pkt_n_ge4", log_q.size() >= 4, 1);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk("pkt_beat", log_q[i], exp_lock[i]);

    // Reset while a beat is held.
    set_in(1, 8'h33, 1, 1, 8'h44, 1, 0);
    cycle();
    chk("pre_rst_vld", y_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_vld", y_valid, 0);
    chk("mid_rst_data", y_data, 0);
    chk("mid_rst_sel", y_sel, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(1, 8'h33, 1, 1, 8'h44, 1, 1);
    #1;
    chk("post_rst_a", a_ready, 1);
    chk("post_rst_b", b_ready, 0);
    cycle();
    chk("post_rst_data", y_data, 8'h33);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/arb2_stream.md
ARB2_STREAM -- requirements
Module: arb2_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each data path.
REQ-002 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: a_valid/a_ready/a_last  in/out/in  1  source A handshake and packet end.
REQ-005 SHALL have ports: a_data  input  DATA_W  source A payload.
REQ-006 SHALL have ports: b_valid/b_ready/b_last  in/out/in  1  source B handshake and packet end.
REQ-007 SHALL have ports: b_data  input  DATA_W  source B payload.
REQ-008 SHALL have ports: y_valid/y_ready/y_last  out/in/out  1  merged output handshake.
REQ-009 SHALL have ports: y_data  output  DATA_W  merged payload; y_sel  output  1  source of held beat (0=A, 1=B), the select fed to the downstream 2:1 mux.

Function
REQ-010 SHALL transfer a beat on a port when valid and ready are both 1 on a rising clk edge.
REQ-011 SHALL hold one output beat in a register; y_* outputs driven only from that register (latency 1 cycle, input accept to y_valid).
REQ-012 SHALL be able to load when register empty or y_ready=1 in the same cycle (full throughput, 1 beat/cycle).
REQ-013 a_ready/b_ready SHALL be combinational: at most one is 1 per cycle, only for the granted source, only when load allowed.
REQ-014 Grant: only one valid -> that source; both valid -> source named by priority pointer prio.
REQ-015 prio SHALL toggle to the non-granted source after every accepted beat (round-robin); unchanged when nothing accepted.
REQ-016 While y_valid=1 and y_ready=0, y_data/y_last/y_sel SHALL remain stable and both input readies SHALL be 0.
REQ-017 Neither source valid and y_ready=1 -> y_valid SHALL drop to 0 next cycle.
REQ-018 A source deasserting valid without a transfer SHALL not affect prio or the held beat.

Reset
REQ-019 rst=1 SHALL immediately force y_valid=0, y_data=0, y_last=0, y_sel=0, prio=A, lock cleared, independent of clk.
REQ-020 Beat held at reset assertion SHALL be discarded; first grant after release follows REQ-014 with prio=A.

Configuration
REQ-021 Macro ARB2_LOCK_EN SHALL select packet locking.
REQ-022 With ARB2_LOCK_EN: after a granted beat with last=0, grant SHALL stay on that source (other ready held 0) until a beat with last=1 is accepted; prio toggles only on accepted last beats.
REQ-023 Without ARB2_LOCK_EN: a_last/b_last SHALL pass through to y_last only; arbitration per beat per REQ-015.

Structure
REQ-024 Shared package arb2_pkg SHALL hold source encoding constants SRC_A=0, SRC_B=1 and default data width constant.
REQ-025 Data/last selection SHALL use sub-module mux2, one instance per bit via generate, sel driven by grant.
REQ-026 Arbitration state (prio, lock, lock owner) SHALL live in the top module; no other sub-modules.

Verification
REQ-027 Reset: rst=1 mid-transfer with y_valid=1 -> y_valid=0 same time step; after release, A and B both valid -> A granted first.
REQ-028 Contention: A,B valid continuously, y_ready=1, data A=0x11, B=0x22 -> y_data 0x11,0x22,0x11,0x22 on consecutive cycles, y_sel 0,1,0,1.
REQ-029 Backpressure: y_valid=1 with 0x11, y_ready=0 for 3 cycles -> y_data stays 0x11, a_ready=b_ready=0; y_ready=1 -> next beat next cycle.
REQ-030 Single source: only B valid 4 beats 0x01..0x04, y_ready=1 -> outputs 0x01..0x04 back-to-back, y_sel=1, no idle cycles.
REQ-031 Lock (ARB2_LOCK_EN): A sends 3-beat packet (last on beat 3), B valid throughout -> three A beats then B; without macro -> A,B,A interleave.
REQ-032 Idle: all valids 0, y_ready=1 after last beat -> y_valid=0 next cycle, prio unchanged.
